counter_2bit: RTL and testbench
===============================

Name: counter_2bit

Overview:
- Synchronous up/down binary counter, 2 bits wide by default.
- Advances one step on every rising clock edge; the up_down input selects the direction.
- Leaf block used as a small sequencing/state element.
- Has no enable input: the counter moves every cycle it is out of reset.

Parameters:
- WIDTH, 2, counter width in bits; must be ≥1; the count range is 0..2^WIDTH-1.
- RESET_VALUE, 0, value loaded into count on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- up_down  input  1  direction: 1 = count up, 0 = count down; sampled on the rising edge of clk.
- count  output  WIDTH  current counter value, driven directly from a register.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap-around edge.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset.
  - reset = 0 forces count = RESET_VALUE and wrap = 0 immediately, without waiting for a clock edge.
  - Both outputs hold those values while reset = 0.
- Reset release: count starts changing at the first rising clk edge where reset = 1 is sampled.
  - Deassertion of reset must be synchronised externally.
- Count step, at each rising edge with reset = 1:
  - up_down = 1: count <= count + 1 modulo 2^WIDTH.
  - up_down = 0: count <= count - 1 modulo 2^WIDTH.
- Latency: count reflects the new value one clock after up_down is sampled. There is no hold state.
- Wrap-around, default width:
  - Up: 3 -> 0.
  - Down: 0 -> 3.
- wrap flag:
  - Set to 1 for exactly one cycle when the preceding edge performed a wrap: up from 2^WIDTH-1, or down from 0.
  - Otherwise 0.
  - Registered together with count, so wrap and the wrapped count value appear in the same cycle.
- Direction change: takes effect on the very next edge with no turnaround cycle.
  - Example: count = 2, up_down goes 1->0 -> next count = 1.
- Reset mid-operation: count returns to RESET_VALUE asynchronously and any pending wrap pulse is cleared.
- Unknowns: if up_down is X or Z, count becomes X. Verification treats this as a stimulus error; the RTL does not filter it.
- Implementation:
  - Purely synchronous datapath: one WIDTH-bit register and one flag register.
  - No combinational path from up_down to count.

Optional Feature:
- Macro: COUNTER_2BIT_SAT_EN.
- Defined (saturating mode):
  - Counting up at 2^WIDTH-1 holds at 2^WIDTH-1.
  - Counting down at 0 holds at 0.
  - wrap is instead asserted for one cycle on each edge where a step is blocked by saturation.
- Undefined (default): modulo wrap-around exactly as in Behaviour.

Test Plan:
- Reset: hold reset = 0 for 3 cycles while toggling up_down -> count = 0, wrap = 0 throughout. Release -> first edge gives count = 1 if up_down = 1.
- Up sweep: up_down = 1 for 6 edges from 0 -> count 1, 2, 3, 0, 1, 2; wrap = 1 only in the cycle count shows 0.
- Down sweep: up_down = 0 for 5 edges from 0 -> count 3, 2, 1, 0, 3; wrap = 1 in the cycles showing the first 3 and the final 3.
- Direction change: up to count = 2, then up_down = 0 -> count 1, then 0; no wrap.
- Async reset mid-count: at count = 3, pull reset low between edges -> count = 0 before the next clk edge; wrap stays 0.
- Saturation (COUNTER_2BIT_SAT_EN defined): up_down = 1 for 5 edges from 0 -> 1, 2, 3, 3, 3; wrap high on the 4th and 5th edges. Without the macro, the same stimulus yields 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/counter_2bit.sv
// Up/down binary counter with a registered wrap pulse.
// Define COUNTER_2BIT_SAT_EN to saturate at the ends instead of wrapping.
module counter_2bit #(
    parameter int WIDTH       = 2,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_at_end;

    // w_at_end: this edge would step past the end of the range in the chosen direction
    always_comb begin
        w_at_end = up_down ? (r_count == MAX_VAL) : (r_count == '0);
`ifdef COUNTER_2BIT_SAT_EN
        w_count_nxt = w_at_end ? r_count : (up_down ? r_count + ONE : r_count - ONE);
`else
        w_count_nxt = up_down ? r_count + ONE : r_count - ONE;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= RST_VAL;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_at_end;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_counter_2bit.sv
// Bench for counter_2bit: directed test-plan steps followed by random
// direction/reset stimulus, checked against an integer-range model.
module tb_counter_2bit;

    localparam int W    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         up_down = 1'b0;
    logic [W-1:0] count;
    logic         wrap;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    bit m_wrap = 1'b0;

    counter_2bit #(.WIDTH(W), .RESET_VALUE(0)) dut (
        .clk(clk), .reset(reset), .up_down(up_down), .count(count), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        checks++;
        assert (count === W'(m_cnt)) else begin
            errors++;
            $error("FAIL %s count: got %0d want %0d", tag, count, m_cnt);
        end
        checks++;
        assert (wrap === m_wrap) else begin
            errors++;
            $error("FAIL %s wrap: got %0b want %0b", tag, wrap, m_wrap);
        end
    endtask

    // Model: take the signed step, then decide what happens off the ends of 0..MAXV
    task automatic model_step(input bit dir);
        int nxt;
        nxt = m_cnt + (dir ? 1 : -1);
        m_wrap = (nxt < 0) || (nxt > MAXV);
`ifdef COUNTER_2BIT_SAT_EN
        if (nxt < 0) nxt = 0;
        if (nxt > MAXV) nxt = MAXV;
`else
        nxt = (nxt + MAXV + 1) % (MAXV + 1);
`endif
        m_cnt = nxt;
    endtask

    task automatic step(input bit dir, input string tag);
        up_down = dir;
        @(posedge clk);
        #1;
        model_step(dir);
        check(tag);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        m_cnt  = 0;
        m_wrap = 1'b0;
        check("async_reset");
        @(posedge clk);
        #1;
        check("reset_hold");
        reset = 1'b1;
    endtask

    initial begin
        // Reset held across edges while up_down toggles
        #1;
        m_cnt  = 0;
        m_wrap = 1'b0;
        check("reset_init");
        for (int i = 0; i < 3; i++) begin
            up_down = i[0];
            @(posedge clk);
            #1;
            check("reset_held");
        end
        reset = 1'b1;
        step(1'b1, "release_first");
        do_reset();

        for (int i = 0; i < 6; i++) step(1'b1, "up_sweep");
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, "down_sweep");
        do_reset();

        step(1'b1, "dir_up");
        step(1'b1, "dir_up");
        step(1'b0, "dir_change");
        step(1'b0, "dir_down");
        do_reset();

        // Reset mid-count at 3, then reset during a pending wrap pulse
        for (int i = 0; i < 3; i++) step(1'b1, "to_three");
        do_reset();
        step(1'b0, "wrap_pending");
        do_reset();

        for (int i = 0; i < 5; i++) step(1'b1, "sat_stim");
        do_reset();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            else step(1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
